// File: rtl/seg_seq_pkg.sv
// Shared types and constants for the segment-pattern display sequencer.
package seg_seq_pkg;
  localparam int SEG_W        = 5;
  localparam int NUM_PATTERNS = 8;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_STEP} seq_state_e;

  // {a,b,c,d,g} per index; entry 0 is the rightmost element
  localparam logic [NUM_PATTERNS-1:0][SEG_W-1:0] PATTERNS = {
    5'b10011, 5'b11100, 5'b00000, 5'b00010,
    5'b11110, 5'b10000, 5'b11101, 5'b10010
  };
endpackage

// File: rtl/segment_sequencer_if.sv
// Control/status bundle between the display sequencer and its driver.
interface segment_sequencer_if;
  import seg_seq_pkg::*;
  logic             clear, run, step, dir;
  logic [3:0]       rate;
  logic [IDX_W-1:0] index;
  logic [SEG_W-1:0] seg;
  logic             adv, wrap, running;

  modport master (output clear, run, step, dir, rate,
                  input  index, seg, adv, wrap, running);
  modport slave  (input  clear, run, step, dir, rate,
                  output index, seg, adv, wrap, running);
endinterface

// File: rtl/seg_pattern_rom.sv
// Combinational pattern index -> {a,b,c,d,g} lookup, shared by display drivers.
module seg_pattern_rom import seg_seq_pkg::*; (
  input  logic [IDX_W-1:0] index,
  output logic [SEG_W-1:0] seg
);
  assign seg = PATTERNS[index];
endmodule

// File: rtl/segment_sequencer.sv
// Pattern index sequencer: free-run at 2^rate, pause, or single-step.
// Define SEQ_STEP_DEBOUNCE_EN to require 4 stable high samples on step.
module segment_sequencer import seg_seq_pkg::*; #(
  parameter int DIV_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  segment_sequencer_if.slave  bus
);
  localparam logic [3:0] RATE_MAX = 4'(DIV_W-1);

  seq_state_e       state_q, state_d;
  logic [1:0]       run_sync, step_sync, dir_sync;
  logic             run_s, step_s, dir_s, step_f, step_q, step_rise;
  logic [DIV_W-1:0] cnt_q, thresh;
  logic [3:0]       rate_eff;
  logic [IDX_W-1:0] index_q;
  logic             adv_q, wrap_q, hit, do_adv;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      run_sync  <= '0;
      step_sync <= '0;
      dir_sync  <= '0;
    end else begin
      run_sync  <= {run_sync[0],  bus.run};
      step_sync <= {step_sync[0], bus.step};
      dir_sync  <= {dir_sync[0],  bus.dir};
    end

  assign run_s  = run_sync[1];
  assign step_s = step_sync[1];
  assign dir_s  = dir_sync[1];

`ifdef SEQ_STEP_DEBOUNCE_EN
  // deb_cnt holds the number of prior consecutive high samples (saturating)
  logic [1:0] deb_cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset)                      deb_cnt <= '0;
    else if (bus.clear || !step_s)  deb_cnt <= '0;
    else if (deb_cnt != 2'd3)       deb_cnt <= deb_cnt + 2'd1;
  assign step_f = step_s && (deb_cnt == 2'd3);
`else
  assign step_f = step_s;
`endif

  assign step_rise = step_f && !step_q;
  assign rate_eff  = (bus.rate > RATE_MAX) ? RATE_MAX : bus.rate;
  assign thresh    = (DIV_W'(1) << rate_eff) - DIV_W'(1);

  always_comb begin
    state_d = state_q;
    do_adv  = 1'b0;
    hit     = (cnt_q >= thresh);
    unique case (state_q)
      S_IDLE, S_PAUSE:
        if (run_s)          state_d = S_RUN;
        else if (step_rise) state_d = S_STEP;
      S_RUN: begin
        do_adv = hit;
        if (!run_s) state_d = S_PAUSE;
      end
      S_STEP: begin
        do_adv  = 1'b1;
        state_d = run_s ? S_RUN : S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.clear) begin
      state_d = S_IDLE;
      do_adv  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      adv_q   <= 1'b0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.clear) begin
        cnt_q   <= '0;
        index_q <= '0;
        adv_q   <= 1'b0;
        wrap_q  <= 1'b0;
        step_q  <= 1'b0;
      end else begin
        step_q <= step_f;
        // prescaler restarts on RUN entry and is frozen outside RUN
        if (state_d == S_RUN && state_q != S_RUN) cnt_q <= '0;
        else if (state_q == S_RUN)                cnt_q <= hit ? '0 : cnt_q + DIV_W'(1);
        if (do_adv) index_q <= dir_s ? index_q - 3'd1 : index_q + 3'd1;
        adv_q  <= do_adv;
        wrap_q <= do_adv && (dir_s ? (index_q == 3'd0) : (index_q == 3'd7));
      end
    end

  seg_pattern_rom u_rom (.index(index_q), .seg(bus.seg));

  assign bus.index   = index_q;
  assign bus.adv     = adv_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = (state_q == S_RUN);
endmodule

// File: tb/tb_segment_sequencer.sv
// Random and directed stimulus against an edge-level behavioural model.
module tb_segment_sequencer;
  import seg_seq_pkg::*;
  localparam int DIV_W = 10;
  localparam logic [4:0] PAT [8] = '{5'b10010, 5'b11101, 5'b10000, 5'b11110,
                                     5'b00010, 5'b00000, 5'b11100, 5'b10011};
`ifdef SEQ_STEP_DEBOUNCE_EN
  localparam int STEP_LAT = 7;
  localparam int PRESS    = 6;
`else
  localparam int STEP_LAT = 4;
  localparam int PRESS    = 2;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3;

  logic clock = 1'b0;
  logic reset;
  int   total = 0, bad = 0;

  segment_sequencer_if bus();
  segment_sequencer #(.DIV_W(DIV_W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // model: mode, index, cycles spent in RUN since entry/last advance
  int m_st = M_IDLE, m_idx = 0, m_since = 0, streak = 0;
  bit m_adv = 0, m_wrap = 0, f_prev = 0;
  bit r1 = 0, r2 = 0, d1 = 0, d2 = 0, s1 = 0, s2 = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st = M_IDLE; m_idx = 0; m_since = 0; streak = 0;
      m_adv = 0; m_wrap = 0; f_prev = 0;
      r1 = 0; r2 = 0; d1 = 0; d2 = 0; s1 = 0; s2 = 0;
    end else begin
      bit f, rise, go;
      int per;
      streak = s2 ? ((streak < 100) ? streak + 1 : streak) : 0;
`ifdef SEQ_STEP_DEBOUNCE_EN
      f = (streak >= 4);
`else
      f = s2;
`endif
      rise = f && !f_prev;
      per  = 1 << ((bus.rate > DIV_W-1) ? DIV_W-1 : int'(bus.rate));
      go   = 0;
      if (bus.clear) begin
        m_st = M_IDLE; m_idx = 0; m_since = 0; m_adv = 0; m_wrap = 0;
        f_prev = 0; streak = 0;
      end else begin
        f_prev = f;
        case (m_st)
          M_RUN: begin
            m_since++;
            if (m_since >= per) begin go = 1; m_since = 0; end
            if (!r2) m_st = M_PAUSE;
          end
          M_STEP: begin
            go = 1; m_since = 0;
            m_st = r2 ? M_RUN : M_PAUSE;
          end
          default:
            if (r2) begin m_st = M_RUN; m_since = 0; end
            else if (rise) m_st = M_STEP;
        endcase
        m_wrap = go && (d2 ? (m_idx == 0) : (m_idx == 7));
        if (go) m_idx = (m_idx + (d2 ? 7 : 1)) % 8;
        m_adv = go;
      end
      r2 = r1; r1 = bus.run;
      d2 = d1; d1 = bus.dir;
      s2 = s1; s1 = bus.step;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [10:0] exp;
    @(negedge clock);
    exp = {3'(m_idx), PAT[m_idx], m_adv, m_wrap, (m_st == M_RUN)};
    chk("cycle", {bus.index, bus.seg, bus.adv, bus.wrap, bus.running}, exp);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  initial begin
    int n, cnt_adv, cnt_wrap, lat;
    reset = 1'b1;
    bus.clear = 0; bus.run = 0; bus.step = 0; bus.dir = 0; bus.rate = 0;
    repeat (2) @(negedge clock);
    tick();
    chk("rst_index", bus.index, 0);
    chk("rst_seg", bus.seg, 5'b10010);
    chk("rst_flags", {bus.adv, bus.wrap, bus.running}, 0);
    reset = 1'b0;
    cnt_adv = 0;
    repeat (20) begin tick(); if (bus.index != 0 || bus.adv || bus.running) cnt_adv++; end
    chk("idle_stable", cnt_adv, 0);

    // free-run increment, period 4
    bus.rate = 2; bus.run = 1; cnt_adv = 0; cnt_wrap = 0;
    repeat (40) begin tick(); cnt_adv += int'(bus.adv); cnt_wrap += int'(bus.wrap); end
    chk("run_adv_count", cnt_adv, 9);
    chk("run_wrap_count", cnt_wrap, 1);

    // decrement every cycle from 0
    bus.run = 0; repeat (4) tick(); pulse_clear();
    bus.rate = 0; bus.dir = 1; bus.run = 1;
    n = 0; while (!bus.adv && n < 10) begin tick(); n++; end
    chk("dec_first", {bus.index, bus.wrap}, {3'd7, 1'b1});
    chk("dec_seg7", bus.seg, 5'b10011);
    tick(); chk("dec_second", bus.index, 6);
    tick(); chk("dec_third", bus.index, 5);

    // single step with a held button
    bus.run = 0; bus.dir = 0; repeat (4) tick(); pulse_clear();
    repeat (3) begin bus.step = 1; repeat (PRESS) tick(); bus.step = 0; repeat (10) tick(); end
    chk("step_pre_index", bus.index, 3);
    bus.step = 1; lat = 0; cnt_adv = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat == 0 && bus.index != 3) begin lat = i; chk("step_seg", bus.seg, 5'b00010); end
      cnt_adv += int'(bus.adv);
    end
    bus.step = 0; repeat (6) tick();
    chk("step_latency", lat, STEP_LAT);
    chk("step_once", cnt_adv, 1);
    chk("step_index", bus.index, 4);

    // rate drop below the running count
    pulse_clear(); bus.rate = 8; bus.run = 1;
    repeat (103) tick();
    chk("slow_no_adv", bus.index, 0);
    bus.rate = 3; tick();
    chk("rate_drop_adv", bus.adv, 1);
    n = 0; do begin tick(); n++; end while (!bus.adv && n < 20);
    chk("rate_drop_period", n, 8);

    // clear against an advance, then async reset mid-period
    bus.rate = 0; repeat (3) tick();
    bus.clear = 1; tick(); bus.clear = 0;
    chk("clear_wins", {bus.index, bus.adv, bus.running}, 0);
    bus.rate = 3; repeat (5) tick();
    #2 reset = 1'b1;
    #1 chk("areset_now", {bus.index, bus.adv, bus.running}, 0);
    #1 reset = 1'b0;
    n = 0; do begin tick(); n++; end while (!bus.adv && n < 30);
    chk("reset_full_period", n, 11);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 9) == 0)  bus.step = ~bus.step;
      if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(0, 49) == 0)
        bus.rate = ($urandom_range(0, 9) == 0) ? 4'd12 : 4'($urandom_range(0, 3));
      bus.clear = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.clear = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/segment_sequencer.md
# segment_sequencer

Controller that sequences the 8-entry segment-pattern display. It owns the pattern index and decides when it advances: free-running at a programmable rate, paused, or single-stepped from a push-button. It feeds the segment outputs {a,b,c,d,g} on the tile pins and is the only writer of the pattern index.

## Interface
- DIV_W, 16, prescaler counter width; max period 2^(DIV_W-1) cycles
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared
- clear  in  1  synchronous clear to IDLE, index 0; clock-domain signal, not synchronized
- run  in  1  level; 1 = free-run, 0 = pause; 2-flop synchronized
- step  in  1  push-button; rising edge requests one advance; 2-flop synchronized
- dir  in  1  level; 0 = increment, 1 = decrement; 2-flop synchronized
- rate  in  4  advance period = 2^rate cycles; values above DIV_W-1 clamp to DIV_W-1
- index  out  3  current pattern index
- seg  out  5  {a,b,c,d,g}, decoded combinationally from the index register
- adv  out  1  one-cycle pulse, high in the cycle after index changes
- wrap  out  1  one-cycle pulse with adv when index crosses 7->0 (inc) or 0->7 (dec)
- running  out  1  high while in RUN

## Operation
- Pattern decode, index -> {a,b,c,d,g}: 0:10010, 1:11101, 2:10000, 3:11110, 4:00010, 5:00000, 6:11100, 7:10011.
- States: IDLE, RUN, PAUSE, STEP. Encoded as an enum.
- IDLE: run=1 -> RUN. Step edge -> STEP.
- RUN: run=0 -> PAUSE. Step edges are ignored.
- PAUSE: run=1 -> RUN. Step edge -> STEP.
- STEP: lasts one cycle and performs one advance. Then goes to RUN if run=1, else PAUSE.
- clear has priority over everything. It forces IDLE, index 0, prescaler 0, and the edge detector to idle.
- Prescaler: counts only in RUN and is frozen in other states. When cnt >= 2^rate-1, it advances and cnt <= 0; otherwise cnt++.
  - The >= compare means a mid-period rate decrease below the current count advances on the next cycle.
  - rate=0 gives an advance every cycle.
  - The prescaler resets to 0 on entering RUN.
- Advance: index +/-1 modulo 8 per dir, using 3-bit natural wrap. dir is sampled at the advance edge.
- The step edge detector produces one request per rising edge. Holding step high gives exactly one advance.

## Timing
- Reset values: index=0, seg=10010, adv=0, wrap=0, running=0, state=IDLE, prescaler=0, synchronizers 0.
- run change: the state transition occurs at the 3rd edge after run changes (2 sync + 1 FSM).
- step, without debounce: if step is first sampled high at edge k, STEP is entered at edge k+2 and index changes at edge k+3.
- step, with debounce: the same sequence lands at edge k+6.
- RUN, constant rate r: index changes every 2^r cycles. The first change is 2^r edges after RUN entry.
- seg follows index in the same cycle with no extra register.
- adv and wrap are registered and high for exactly the one cycle after each index update.
- Asynchronous reset mid-period discards the partial count.
- clear and an advance in the same cycle: clear wins, index=0, no adv.

## Configuration
- SEQ_STEP_DEBOUNCE_EN defined: the synchronized step must be high for 4 consecutive cycles before the edge detector sees it. Any low sample restarts the filter. Index changes at edge k+6.
- Not defined: the synchronized step feeds the edge detector directly. Index changes at edge k+3, and a one-cycle glitch after sync counts as a press.

## Structure
- Package seg_seq_pkg:
  - state enum
  - SEG_W=5
  - pattern constant array (8 x 5)
  - NUM_PATTERNS=8
- Sub-module seg_pattern_rom: combinational index -> seg lookup. It is reused by any other block driving the display.
- Synchronizers and the debounce filter stay inline.

## Test plan
- Reset, then release with run=0 -> index=0, seg=10010, running=0, all outputs stable for 20 cycles.
- run=1, rate=2, dir=0 -> index 1,2,…,7,0 every 4 cycles; wrap pulses exactly once at 7->0; adv pulses once per change.
- run=1, rate=0, dir=1 from index 0 -> index 7,6,5 on consecutive cycles; wrap is high with the first change; seg=10011 when index=7.
- PAUSE at index 3, step held high 10 cycles -> exactly one advance to 4 at k+3 (k+6 with SEQ_STEP_DEBOUNCE_EN); seg=00010.
- RUN with rate=8, cnt=100; switch rate to 3 -> advance on the next cycle, then every 8 cycles.
- clear asserted during an advance cycle, and asynchronous reset mid-period -> index=0, no adv, state IDLE; RUN after reset waits a full 2^rate cycles.
